// File: rtl/x_tdc_capture_decode.sv
// x_tdc_capture_decode: samples the delay-line tap bus and detects a departure
// from a quiet baseline. Each departure becomes a {coarse, fine} timestamp.
//   i_clk, i_rst   : clock; asynchronous active-high reset
//   i_data         : tap snapshot, sampled into s0 on every edge
//   i_arm          : level; capture is enabled while high
//   i_ready        : consumer accepts o_time when high together with o_valid
//   o_valid/o_time : single-slot result register holding {coarse, fine}
//   o_armed        : high while waiting for an edge
//   o_drop_cnt     : saturating count of results lost to a full slot
module x_tdc_capture_decode #(
   parameter int WIDTH = 32,
   parameter int CW    = 16,
   parameter int FW    = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_arm,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [CW+FW-1:0] o_time,
   output logic             o_armed,
   output logic [7:0]       o_drop_cnt
);

   localparam int QW = WIDTH / 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BASE,
      S_ARMED,
      S_HOLD
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_launch;
   logic               w_base_ld;

   logic [WIDTH-1:0]   r_s0;
   logic [WIDTH-1:0]   r_base;
   logic [CW-1:0]      r_coarse;
   logic [WIDTH-1:0]   w_diff;
   logic               w_diff_any;

   logic               r_p1_vld;
   logic [WIDTH-1:0]   r_p1_diff;
   logic [CW-1:0]      r_p1_coarse;

   // popcount is split: quarter sums in P2, final add in P3
   logic [FW-1:0]      w_part [4];
   logic               r_p2_vld;
   logic [FW-1:0]      r_p2_part [4];
   logic [CW-1:0]      r_p2_coarse;

   logic [FW-1:0]      w_fine;
   logic               r_p3_vld;
   logic [FW-1:0]      r_p3_fine;
   logic [CW-1:0]      r_p3_coarse;

   logic               r_valid;
   logic [CW+FW-1:0]   r_time;
   logic [7:0]         r_drop;

   assign w_diff     = r_s0 ^ r_base;
   assign w_diff_any = |w_diff;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s0     <= '0;
         r_base   <= '0;
         r_coarse <= '0;
         r_state  <= S_IDLE;
      end else begin
         r_s0     <= i_data;
         r_coarse <= r_coarse + 1'b1;
         r_state  <= w_next;
         if (w_base_ld)
            r_base <= r_s0;
      end
   end

   // disarm wins over a launch seen in the same cycle
   always_comb begin
      w_next    = r_state;
      w_launch  = 1'b0;
      w_base_ld = 1'b0;
      unique case (r_state)
         S_IDLE:
            if (i_arm)
               w_next = S_BASE;
         S_BASE: begin
            w_base_ld = 1'b1;
            w_next    = S_ARMED;
         end
         S_ARMED:
            if (!i_arm) begin
               w_next = S_IDLE;
            end else if (w_diff_any) begin
               w_launch = 1'b1;
               w_next   = S_HOLD;
            end
         S_HOLD:
            if (!w_diff_any)
               w_next = i_arm ? S_ARMED : S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   // bubbles are counted, never rejected
   always_comb begin
      for (int q = 0; q < 4; q++) begin
         w_part[q] = '0;
         for (int b = 0; b < QW; b++)
            w_part[q] = w_part[q] + FW'(r_p1_diff[q*QW+b]);
      end
   end

   assign w_fine = r_p2_part[0] + r_p2_part[1]
                 + r_p2_part[2] + r_p2_part[3];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_p1_vld    <= 1'b0;
         r_p1_diff   <= '0;
         r_p1_coarse <= '0;
         r_p2_vld    <= 1'b0;
         r_p2_coarse <= '0;
         for (int q = 0; q < 4; q++)
            r_p2_part[q] <= '0;
         r_p3_vld    <= 1'b0;
         r_p3_fine   <= '0;
         r_p3_coarse <= '0;
      end else begin
         r_p1_vld <= w_launch;
         if (w_launch) begin
            r_p1_diff   <= w_diff;
            r_p1_coarse <= r_coarse;
         end
         r_p2_vld    <= r_p1_vld;
         r_p2_coarse <= r_p1_coarse;
         for (int q = 0; q < 4; q++)
            r_p2_part[q] <= w_part[q];
         r_p3_vld    <= r_p2_vld;
         r_p3_fine   <= w_fine;
         r_p3_coarse <= r_p2_coarse;
      end
   end

   // a consume in the same edge frees the slot for the new arrival
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_time  <= '0;
         r_drop  <= '0;
      end else if (r_p3_vld) begin
         if (!r_valid || i_ready) begin
            r_valid <= 1'b1;
            r_time  <= {r_p3_coarse, r_p3_fine};
         end else if (r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
         end
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid    = r_valid;
   assign o_time     = r_time;
   assign o_armed    = (r_state == S_ARMED);
   assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_x_tdc_capture_decode.sv
// tb_x_tdc_capture_decode: directed bench for x_tdc_capture_decode with an
// event-level reference model checked every cycle.
module tb_x_tdc_capture_decode;

   logic        clk;
   logic        rst;
   logic [31:0] data;
   logic        arm;
   logic        ready;
   logic        valid;
   logic [21:0] tim;
   logic        armed;
   logic [7:0]  drop;

   int total = 0;
   int bad   = 0;

   x_tdc_capture_decode dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_data     (data),
      .i_arm      (arm),
      .i_ready    (ready),
      .o_valid    (valid),
      .o_time     (tim),
      .o_armed    (armed),
      .o_drop_cnt (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int M_IDLE  = 0;
   localparam int M_BASE  = 1;
   localparam int M_ARMED = 2;
   localparam int M_HOLD  = 3;

   typedef struct {
      longint      due;
      logic [15:0] c;
      logic [5:0]  f;
   } ev_t;

   ev_t         q[$];
   int          mode;
   longint      ecnt;
   logic [31:0] m_s0;
   logic [31:0] m_base;
   logic [15:0] m_cnt;
   logic        m_valid;
   logic [21:0] m_time;
   logic [7:0]  m_drop;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         mode    = M_IDLE;
         ecnt    = 0;
         m_s0    = '0;
         m_base  = '0;
         m_cnt   = '0;
         m_valid = 1'b0;
         m_time  = '0;
         m_drop  = '0;
      end else begin
         ecnt++;
         if (q.size() > 0 && q[0].due == ecnt) begin
            if (!m_valid || ready) begin
               m_valid = 1'b1;
               m_time  = {q[0].c, q[0].f};
            end else if (m_drop < 8'd255) begin
               m_drop = m_drop + 8'd1;
            end
            void'(q.pop_front());
         end else if (m_valid && ready) begin
            m_valid = 1'b0;
         end
         case (mode)
            M_IDLE:  if (arm) mode = M_BASE;
            M_BASE: begin
               m_base = m_s0;
               mode   = M_ARMED;
            end
            M_ARMED:
               if (!arm) mode = M_IDLE;
               else if (m_s0 != m_base) begin
                  q.push_back('{ecnt + 3, m_cnt,
                                6'($countones(m_s0 ^ m_base))});
                  mode = M_HOLD;
               end
            default:
               if (m_s0 == m_base) mode = arm ? M_ARMED : M_IDLE;
         endcase
         m_s0  = data;
         m_cnt = m_cnt + 16'd1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_valid", 32'(valid), 32'(m_valid));
         chk("m_armed", 32'(armed), 32'(mode == M_ARMED));
         chk("m_drop", 32'(drop), 32'(m_drop));
         if (m_valid)
            chk("m_time", 32'(tim), 32'(m_time));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_v(input int n, output bit ok, input string nm);
      ok = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({nm, "_timeout"}, 32'(valid), 32'd1);
   endtask

   task automatic cap(input logic [31:0] d, input int f, input string nm);
      bit ok;
      data = d;
      wait_v(12, ok, nm);
      if (ok) chk({nm, "_fine"}, 32'(tim[5:0]), 32'(f));
   endtask

   initial begin
      bit          ok;
      logic [15:0] c0;
      rst   = 1'b1;
      data  = '0;
      arm   = 1'b0;
      ready = 1'b1;
      #12;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_time", 32'(tim), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_armed", 32'(armed), 32'd0);
      step(1);
      rst = 1'b0;

      // basic capture and latency
      arm = 1'b1;
      step(5);
      chk("armed_up", 32'(armed), 32'd1);
      c0   = m_cnt;
      data = 32'hCCCCCCCC;
      repeat (5) @(negedge clk);
      chk("lat_early", 32'(valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(valid), 32'd1);
      chk("basic_time", 32'(tim), 32'({c0 + 16'd1, 6'd16}));
      @(negedge clk);
      chk("pulse_end", 32'(valid), 32'd0);

      // rearm
      @(posedge clk);
      #2;
      data = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rearm_early", 32'(armed), 32'd0);
      @(negedge clk);
      chk("rearm_up", 32'(armed), 32'd1);
      step(1);
      cap(32'h0000FFFF, 16, "half");
      step(1);
      data = '0;
      step(3);
      cap(32'h00000001, 1, "one");
      step(1);
      data = '0;
      step(3);

      // non-zero baseline
      arm = 1'b0;
      step(2);
      data = 32'hFFFFFFFF;
      step(2);
      arm = 1'b1;
      step(4);
      chk("nz_armed", 32'(armed), 32'd1);
      step(10);
      chk("steady", 32'(valid), 32'd0);
      cap(32'h0000FFFF, 16, "nzbase");
      step(1);
      data = 32'hFFFFFFFF;
      step(3);

      // backpressure
      ready = 1'b0;
      cap(32'hFFFFFF00, 8, "bp1");
      step(1);
      data = 32'hFFFFFFFF;
      step(3);
      data = 32'hFFFF0000;
      step(8);
      chk("bp_drop", 32'(drop), 32'd1);
      chk("bp_hold", 32'(tim[5:0]), 32'd8);
      chk("bp_valid", 32'(valid), 32'd1);
      data = 32'hFFFFFFFF;
      step(3);
      data = 32'hFFFFFFF0;
      repeat (4) @(posedge clk);
      #2;
      ready = 1'b1;
      @(posedge clk);
      #2;
      ready = 1'b0;
      chk("bp3_valid", 32'(valid), 32'd1);
      chk("bp3_fine", 32'(tim[5:0]), 32'd4);
      chk("bp3_drop", 32'(drop), 32'd1);
      ready = 1'b1;
      step(2);
      data = 32'hFFFFFFFF;
      step(3);

      // disarm in the launch cycle
      data = 32'h00000000;
      @(posedge clk);
      #2;
      arm = 1'b0;
      step(8);
      chk("dis_valid", 32'(valid), 32'd0);
      chk("dis_armed", 32'(armed), 32'd0);

      // capture across the coarse wrap
      arm = 1'b1;
      step(4);
      ok = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         if (m_cnt == 16'hFFFE) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      if (!ok) chk("wrap_reach", 32'(m_cnt), 32'hFFFE);
      cap(32'h0F0F0000, 8, "wrap");
      chk("wrap_time", 32'(tim), 32'({16'hFFFF, 6'd8}));
      step(1);
      data = '0;
      step(3);

      // reset while holding a result
      ready = 1'b0;
      cap(32'h000000FF, 8, "mid");
      chk("mid_drop", 32'(drop), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_valid", 32'(valid), 32'd0);
      chk("mr_time", 32'(tim), 32'd0);
      chk("mr_drop", 32'(drop), 32'd0);
      chk("mr_armed", 32'(armed), 32'd0);
      step(2);
      arm = 1'b0;
      rst = 1'b0;
      step(3);
      chk("mr_idle", 32'(armed), 32'd0);
      chk("mr_quiet", 32'(valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
